// File: rtl/dsp7seg_pkg.sv
// Shared types, 7-segment code constants and BCD-to-segment decoder for dsp7seg_contador_n.
// Codes are stored in active-low form; bcd_to_seg inverts them for active-high panels.
package dsp7seg_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_e;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Non-decimal codes A-F fall through to blank
    function automatic logic [7:0] bcd_to_seg(input bcd_t digit, input logic active_low);
        logic [7:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return active_low ? code : ~code;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD up/down counter chain: steps on 'step', rolls 9->0 or 0->9,
// and raises 'carry' (carry or borrow) combinationally so the next decade steps on the same edge.
module bcd_digit
    import dsp7seg_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic step,
    input  logic dir,
    output bcd_t value,
    output logic carry
);

    logic at_limit;

    assign at_limit = (dir == DIR_UP) ? (value == 4'd9) : (value == 4'd0);
    assign carry    = step & at_limit;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (step) begin
            if (at_limit) begin
                value <= (dir == DIR_UP) ? 4'd0 : 4'd9;
            end else if (dir == DIR_UP) begin
                value <= value + 4'd1;
            end else begin
                value <= value - 4'd1;
            end
        end
    end

endmodule

// File: rtl/dsp7seg_contador_n.sv
// N-digit BCD up/down counter with time-multiplexed 7-segment driver.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module dsp7seg_contador_n
    import dsp7seg_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 1,
    parameter int SCAN_HZ    = 1000,
    parameter int N_DIG      = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic               FPGA_CLK,
    input  logic               FPGA_RST,
    input  logic               EN,
    input  logic               DIR,
    input  logic               CLR,
    output logic [7:0]         SEG,
    output logic [N_DIG-1:0]   DIG,
    output logic [4*N_DIG-1:0] BCD,
    output logic               WRAP
);

    localparam int DIV_T = CLK_HZ / TICK_HZ;
    localparam int DIV_S = CLK_HZ / SCAN_HZ;
    localparam int TW    = $clog2(DIV_T);
    localparam int SW    = $clog2(DIV_S);
    localparam int IW    = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    if (DIV_T < 2 || DIV_S < 2 || N_DIG < 1 || N_DIG > 8) begin : g_param_check
        $error("dsp7seg_contador_n: illegal parameters (DIV_T=%0d DIV_S=%0d N_DIG=%0d)", DIV_T, DIV_S, N_DIG);
    end

    logic [TW-1:0]    tick_cnt;
    logic             tick;
    logic [N_DIG:0]   step;
    bcd_t             digit_val [N_DIG];
    logic [SW-1:0]    scan_cnt;
    logic             scan_tick;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    next_idx;
    logic [N_DIG-1:0] dig_onehot;
    logic [N_DIG-1:0] blank;
    logic [7:0]       seg_next;

    // Prescaler freezes with EN low so a paused interval resumes where it left off
    assign tick = EN && (tick_cnt == TW'(DIV_T - 1));

    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST || CLR) begin
            tick_cnt <= '0;
        end else if (EN) begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        end
    end

    assign step[0] = tick;

    for (genvar k = 0; k < N_DIG; k++) begin : g_digit
        bcd_digit u_digit (
            .clk   (FPGA_CLK),
            .rst   (FPGA_RST),
            .clr   (CLR),
            .step  (step[k]),
            .dir   (DIR),
            .value (digit_val[k]),
            .carry (step[k+1])
        );
        assign BCD[4*k +: 4] = digit_val[k];
    end

    // Carry out of the top decade is the wrap; a simultaneous clear suppresses it
    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            WRAP <= 1'b0;
        end else begin
            WRAP <= step[N_DIG] && !CLR;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic higher_zero;

    always_comb begin
        higher_zero = 1'b1;
        blank       = '0;
        for (int j = N_DIG - 1; j > 0; j--) begin
            higher_zero = higher_zero && (digit_val[j] == 4'd0);
            blank[j]    = higher_zero;
        end
    end
`else
    assign blank = '0;
`endif

    assign scan_tick = (scan_cnt == SW'(DIV_S - 1));

    always_comb begin
        next_idx   = (idx == IW'(N_DIG - 1)) ? '0 : idx + IW'(1);
        dig_onehot = '0;
        dig_onehot[next_idx] = 1'b1;
        seg_next   = blank[next_idx] ? (ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK)
                                     : bcd_to_seg(digit_val[next_idx], ACTIVE_LOW);
    end

    // DIG and SEG load together on the scan tick so the pins never show a mismatched pair
    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            scan_cnt <= '0;
            idx      <= '0;
            DIG      <= ACTIVE_LOW ? ~N_DIG'(1) : N_DIG'(1);
            SEG      <= bcd_to_seg(4'd0, ACTIVE_LOW);
        end else begin
            scan_cnt <= scan_tick ? '0 : scan_cnt + SW'(1);
            if (scan_tick) begin
                idx <= next_idx;
                DIG <= ACTIVE_LOW ? ~dig_onehot : dig_onehot;
                SEG <= seg_next;
            end
        end
    end

endmodule

// File: tb/tb_dsp7seg_contador_n.sv
// Self-checking bench for dsp7seg_contador_n (DIV_T=10, DIV_S=2, 4 digits, active-low).
// Reference model tracks the count as a plain integer and derives digits arithmetically.
module tb_dsp7seg_contador_n;

    localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic        FPGA_CLK = 1'b0;
    logic        FPGA_RST;
    logic        EN;
    logic        DIR;
    logic        CLR;
    logic [7:0]  SEG;
    logic [3:0]  DIG;
    logic [15:0] BCD;
    logic        WRAP;

    int checks = 0;
    int errors = 0;

    int         m_cnt;
    int         m_pre;
    int         m_scan;
    int         m_idx;
    logic       m_wrap;
    logic [3:0] m_dig;
    logic [7:0] m_seg;

    logic       cur_dir;
    int         seen [4];
    bit         found;

    dsp7seg_contador_n #(
        .CLK_HZ     (100),
        .TICK_HZ    (10),
        .SCAN_HZ    (50),
        .N_DIG      (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .FPGA_CLK (FPGA_CLK),
        .FPGA_RST (FPGA_RST),
        .EN       (EN),
        .DIR      (DIR),
        .CLR      (CLR),
        .SEG      (SEG),
        .DIG      (DIG),
        .BCD      (BCD),
        .WRAP     (WRAP)
    );

    always #5 FPGA_CLK = ~FPGA_CLK;

    function automatic logic [15:0] toBcd(input int v);
        logic [15:0] r;
        int          rem;
        rem = v;
        r   = '0;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return r;
    endfunction

    // Drive inputs, take one edge, then advance the model with the inputs seen at that edge
    task automatic applyStimulus(input logic rst, input logic clr, input logic en, input logic dir);
        int old_cnt;
        int p10;
        bit tick;
        FPGA_RST = rst;
        CLR      = clr;
        EN       = en;
        DIR      = dir;
        @(posedge FPGA_CLK);
        old_cnt = m_cnt;
        if (rst) begin
            m_cnt  = 0;
            m_pre  = 0;
            m_scan = 0;
            m_idx  = 0;
            m_wrap = 1'b0;
            m_dig  = 4'hE;
            m_seg  = 8'hC0;
        end else begin
            tick   = en && (m_pre == 9);
            m_wrap = 1'b0;
            if (clr) begin
                m_cnt = 0;
                m_pre = 0;
            end else if (en) begin
                if (tick) begin
                    if (dir) begin
                        m_wrap = (m_cnt == 9999);
                        m_cnt  = (m_cnt + 1) % 10000;
                    end else begin
                        m_wrap = (m_cnt == 0);
                        m_cnt  = (m_cnt + 9999) % 10000;
                    end
                    m_pre = 0;
                end else begin
                    m_pre++;
                end
            end
            if (m_scan == 1) begin
                m_scan = 0;
                m_idx  = (m_idx + 1) % 4;
                p10 = 1;
                repeat (m_idx) p10 *= 10;
                m_seg = SEG_TAB[(old_cnt / p10) % 10];
`ifdef LEADING_ZERO_BLANK_EN
                if (m_idx > 0 && old_cnt < p10) m_seg = 8'hFF;
`endif
                m_dig = ~(4'b0001 << m_idx);
            end else begin
                m_scan++;
            end
        end
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [15:0] exp_bcd;
        exp_bcd = toBcd(m_cnt);
        checks++;
        assert (BCD === exp_bcd) else begin
            errors++;
            $error("[TB] FAIL %s bcd observed %h expected %h", tag, BCD, exp_bcd);
        end
        checks++;
        assert (WRAP === m_wrap) else begin
            errors++;
            $error("[TB] FAIL %s wrap observed %b expected %b", tag, WRAP, m_wrap);
        end
        checks++;
        assert (DIG === m_dig) else begin
            errors++;
            $error("[TB] FAIL %s dig observed %h expected %h", tag, DIG, m_dig);
        end
        checks++;
        assert (SEG === m_seg) else begin
            errors++;
            $error("[TB] FAIL %s seg observed %h expected %h", tag, SEG, m_seg);
        end
    endtask

    task automatic checkValue(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        $display("[TB] start");
        cur_dir = 1'b1;

        applyStimulus(1, 0, 0, 1);
        checkOutput("reset");
        applyStimulus(1, 0, 0, 1);
        checkValue("reset_dig", DIG, 16'h000E);
        checkValue("reset_seg", SEG, 16'h00C0);
        checkValue("reset_bcd", BCD, 16'h0000);

        for (int c = 0; c < 100; c++) begin
            applyStimulus(0, 0, 1, 1);
            checkOutput("count_up");
        end
        checkValue("up_100_cycles", BCD, 16'h0010);

        applyStimulus(0, 1, 1, 0);
        checkOutput("clear");
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, 0, 1, 0);
            checkOutput("down_wrap");
        end
        checkValue("down_wrap_bcd", BCD, 16'h9999);
        checkValue("down_wrap_flag", WRAP, 16'h0001);
        applyStimulus(0, 0, 1, 1);
        checkOutput("wrap_single");
        checkValue("wrap_single_cycle", WRAP, 16'h0000);
        for (int c = 0; c < 9; c++) begin
            applyStimulus(0, 0, 1, 1);
            checkOutput("up_wrap");
        end
        checkValue("up_wrap_bcd", BCD, 16'h0000);
        checkValue("up_wrap_flag", WRAP, 16'h0001);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, 0, 1, 0);
            checkOutput("down_again");
        end
        checkValue("down_again_bcd", BCD, 16'h9999);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, 0, 1, 0);
            checkOutput("down_step");
        end
        checkValue("down_9998", BCD, 16'h9998);

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 19) == 0) cur_dir = ~cur_dir;
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 7) != 0, cur_dir);
            checkOutput("random");
        end

        applyStimulus(0, 1, 1, 1);
        checkOutput("pause_clear");
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 0, 1, 1);
            checkOutput("pause_pre");
        end
        for (int c = 0; c < 37; c++) begin
            applyStimulus(0, 0, 0, 1);
            checkOutput("paused");
        end
        for (int c = 0; c < 5; c++) begin
            applyStimulus(0, 0, 1, 1);
            checkOutput("resume");
        end
        checkValue("resume_no_tick_yet", BCD, 16'h0000);
        applyStimulus(0, 0, 1, 1);
        checkOutput("resume_tick");
        checkValue("resume_tick_bcd", BCD, 16'h0001);

        applyStimulus(0, 1, 1, 0);
        checkOutput("clr_setup");
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, 0, 1, 0);
            checkOutput("clr_to_9999");
        end
        for (int c = 0; c < 9; c++) begin
            applyStimulus(0, 0, 1, 1);
            checkOutput("clr_pre");
        end
        applyStimulus(0, 1, 1, 1);
        checkOutput("clr_on_tick");
        checkValue("clr_on_tick_bcd", BCD, 16'h0000);
        checkValue("clr_on_tick_wrap", WRAP, 16'h0000);

        applyStimulus(0, 1, 1, 1);
        for (int c = 0; c < 3050; c++) begin
            applyStimulus(0, 0, 1, 1);
            checkOutput("to_0305");
        end
        checkValue("count_0305", BCD, 16'h0305);
        for (int c = 0; c < 8; c++) begin
            applyStimulus(0, 0, 0, 1);
            checkOutput("scan_settle");
        end
        seen = '{0, 0, 0, 0};
        for (int c = 0; c < 16; c++) begin
            applyStimulus(0, 0, 0, 1);
            checkOutput("scan");
            case (DIG)
                4'hE: begin seen[0]++; checkValue("scan_seg_d0", SEG, 16'h0092); end
                4'hD: begin seen[1]++; checkValue("scan_seg_d1", SEG, 16'h00C0); end
                4'hB: begin seen[2]++; checkValue("scan_seg_d2", SEG, 16'h00B0); end
`ifdef LEADING_ZERO_BLANK_EN
                4'h7: begin seen[3]++; checkValue("scan_seg_d3", SEG, 16'h00FF); end
`else
                4'h7: begin seen[3]++; checkValue("scan_seg_d3", SEG, 16'h00C0); end
`endif
                default: checkValue("scan_dig_onehot", DIG, 16'h000E);
            endcase
        end
        for (int d = 0; d < 4; d++) begin
            checkValue($sformatf("scan_slots_d%0d", d), 16'(seen[d]), 16'd4);
        end

        applyStimulus(0, 1, 1, 1);
        for (int c = 0; c < 12340; c++) begin
            applyStimulus(0, 0, 1, 1);
            checkOutput("to_1234");
        end
        checkValue("count_1234", BCD, 16'h1234);
        found = 1'b0;
        for (int c = 0; c < 16 && !found; c++) begin
            applyStimulus(0, 0, 0, 1);
            checkOutput("seek_digit2");
            if (DIG === 4'hB) found = 1'b1;
        end
        checkValue("seek_digit2_found", 16'(found), 16'h0001);
        applyStimulus(1, 0, 0, 1);
        checkOutput("mid_scan_reset");
        checkValue("mid_scan_reset_dig", DIG, 16'h000E);
        checkValue("mid_scan_reset_seg", SEG, 16'h00C0);
        checkValue("mid_scan_reset_bcd", BCD, 16'h0000);
        checkValue("mid_scan_reset_wrap", WRAP, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp7seg_contador_n.md
# dsp7seg_contador_n

Parametrised N-digit decimal up/down counter with a time-multiplexed 7-segment display driver. A prescaler derives the count tick from the board clock. A BCD counter chain holds the value. A scan engine drives one digit at a time with registered, mutually coherent SEG/DIG outputs. The block sits directly on the display pins of the kit and replaces fixed 4-digit, divide-based counting displays.

## Interface
- CLK_HZ, 50_000_000: input clock frequency.
- TICK_HZ, 1: count rate; tick divider DIV_T = CLK_HZ/TICK_HZ, must be ≥ 2.
- SCAN_HZ, 1000: per-digit scan rate; scan divider DIV_S = CLK_HZ/SCAN_HZ, must be ≥ 2.
- N_DIG, 4: number of digits, legal range 1..8.
- ACTIVE_LOW, 1: 1 = SEG and DIG drive low to light; 0 = active-high.
- FPGA_CLK  in  1  sole clock; all logic on its rising edge.
- FPGA_RST  in  1  synchronous, active-high reset.
- EN  in  1  count enable; when low, tick prescaler and count are frozen.
- DIR  in  1  1 = count up, 0 = count down.
- CLR  in  1  synchronous clear of count and tick prescaler.
- SEG  out  8  segment drive; bit7 = dp (always off), bits6..0 = g..a.
- DIG  out  N_DIG  one-hot digit select, polarity per ACTIVE_LOW.
- BCD  out  4*N_DIG  current count; digit k occupies bits 4k+3..4k; digit 0 is least significant.
- WRAP  out  1  one-cycle pulse when the count wraps.

## Operation
- Tick prescaler: counts 0..DIV_T-1 while EN=1. `tick` is high in the cycle where prescaler == DIV_T-1. It then returns to 0.
- Count: on `tick`, the BCD chain steps by one.
  - Up: 9 rolls to 0 with carry to the next digit. All-9s goes to all-0s and asserts WRAP.
  - Down: 0 rolls to 9 with borrow. All-0s goes to all-9s and asserts WRAP.
- No binary-to-BCD division is used anywhere.
- CLR: count := 0 and tick prescaler := 0. CLR takes priority over tick, so WRAP is not asserted when both occur. CLR acts regardless of EN.
- Scan: the scan prescaler runs freely (independent of EN/CLR). On each scan tick, digit index i advances 0,1,…,N_DIG-1,0.
- Display update: on the same edge, DIG := one-hot(i), and SEG := decode of BCD digit i sampled in that cycle. Both are registered together, so they are never mismatched.
- Decode (active-low form), digits 0-9: C0,F9,A4,B0,99,92,82,F8,80,90 hex. Codes A-F display blank (FF). Active-high output is the bitwise inverse.
- Reset values:
  - count 0, both prescalers 0, i = 0;
  - DIG selects digit 0 (active level);
  - SEG = code for "0";
  - WRAP 0; BCD all zero.
- RST at any cycle, including mid-scan or mid-wrap, forces all reset values on the next edge. RST overrides CLR.

## Timing
- Count latency: tick in cycle t → BCD updated at edge t+1. WRAP is high exactly during cycle t+1, aligned with the new BCD value.
- Tick period: exactly DIV_T enabled cycles. Pausing EN preserves prescaler phase, so resume continues the partial interval.
- Display latency: a new BCD value appears on digit k within N_DIG·DIV_S cycles.
- Scan: each digit is active for exactly DIV_S cycles. DIG/SEG change one edge after the scan tick.
- Widths: prescaler widths are $clog2(DIV_T) and $clog2(DIV_S). Illegal parameters raise an elaboration-time error.

## Configuration
- Macro LEADING_ZERO_BLANK_EN.
- Defined: any digit k>0 whose BCD value and all higher digits are 0 displays blank (SEG all off). Digit 0 is never blanked, so value 0 shows a single "0". DIG scanning is unchanged. BCD and WRAP are unaffected.
- Undefined: all digits always display their value, including leading zeros.

## Structure
- Package dsp7seg_pkg:
  - segment code constants SEG_0..SEG_9 and SEG_BLANK (active-low form);
  - function bcd_to_seg(digit, active_low).
- Sub-module bcd_digit: one decade with inc/dec inputs, carry/borrow out, and sync clear. The top level instantiates it N_DIG times in a generate loop, chaining carry/borrow into the next digit's step enable.

## Test plan
Bench uses CLK_HZ=100, TICK_HZ=10 (DIV_T=10), SCAN_HZ=50 (DIV_S=2), N_DIG=4, ACTIVE_LOW=1.
- Reset, then EN=1, DIR=1 for 100 cycles → BCD=0x0010 after the 10th tick. Carry from digit 0 to digit 1 occurs on the same edge.
- Force count 9999 (via 9999 ticks or a preloaded sim), one more tick → BCD=0x0000 and WRAP high for exactly one cycle.
- DIR=0 from 0 → one tick gives BCD=0x9999 with WRAP pulse. Next tick gives 0x9998.
- EN dropped for 37 cycles at prescaler=4 → next tick arrives 5 enabled cycles after EN returns. CLR asserted in a tick cycle → BCD=0, WRAP=0.
- Count 0x0305, observe 8 scan slots → DIG sequence E,D,B,7 (each held 2 cycles). SEG is 92, C0, B0, C0 respectively; with LEADING_ZERO_BLANK_EN, digit 3 shows FF.
- RST asserted mid-scan at i=2 with BCD=0x1234 → next edge: DIG=E, SEG=C0, BCD=0, WRAP=0.
